// File: rtl/sdr_receive.sv
// sdr_receive: receive-side decoder for Protocol 2 payloads (ports 1024/1027/1029).
// Decodes discovery/General, High Priority control and TX I/Q data.
// Optional feature macro: SDR_RX_SEQ_CHECK_EN (per-stream sequence error counters).
module sdr_receive #(
  parameter int          NR         = 2,
  parameter logic [15:0] HP_MIN_LEN = 16'd333
) (
  input  logic             rx_clock,
  input  logic             rst_n,
  input  logic             udp_rx_active,
  input  logic [7:0]       udp_rx_data,
  input  logic [15:0]      to_port,
  input  logic             discovery_ACK,
  input  logic             txiq_full,
  output logic             discovery,
  output logic             run,
  output logic             ptt,
  output logic             wideband,
  output logic [7:0]       wb_packets_per_frame,
  output logic [32*NR-1:0] rx_freq,
  output logic [31:0]      tx_freq,
  output logic             hp_update,
  output logic             txiq_wrreq,
  output logic [7:0]       txiq_wrdata,
  output logic             txiq_overflow,
  output logic [15:0]      seq_err_hp,
  output logic [15:0]      seq_err_iq
);
  typedef enum logic [2:0] {IDLE, SEQ, GENERAL, HIGH_PRI, TX_IQ, SKIP} state_t;
  typedef enum logic [1:0] {ST_GEN, ST_HP, ST_IQ, ST_NONE} stream_t;

  localparam int          RXW     = 32 * NR;
  localparam int          OFFW    = $clog2(RXW);
  localparam logic [15:0] DDC_END = 16'(9 + 4 * NR);

  state_t      state;
  stream_t     stream, port_stream;
  logic [15:0] byte_no;   // index of the byte currently on the bus; packet length at the end
  logic        armed;     // blocks a packet already in flight when reset releases

  // shadow copies of control fields, committed only when the packet ends cleanly
  logic           sh_run, sh_ptt, sh_wb;
  logic [7:0]     sh_ppf;
  logic [RXW-1:0] sh_rx;
  logic [31:0]    sh_tx;

  logic start, byte_in, pkt_end, gen_commit, hp_commit, run_rise, run_fall, disc_set;
  logic [15:0]     ddc_rel;
  logic [OFFW-1:0] ddc_off;

  assign start      = (state == IDLE) && udp_rx_active && armed;
  assign byte_in    = (state != IDLE) && udp_rx_active;
  assign pkt_end    = (state != IDLE) && !udp_rx_active;
  assign gen_commit = pkt_end && (state == GENERAL) && (byte_no > 16'd28);
  assign hp_commit  = pkt_end && (state == HIGH_PRI) && (byte_no >= HP_MIN_LEN);
  assign run_rise   = hp_commit && !run && sh_run;
  assign run_fall   = hp_commit && run && !sh_run;
  assign disc_set   = byte_in && (state == GENERAL) && (byte_no == 16'd4) &&
                      (udp_rx_data == 8'h02);

  // DDC k occupies bytes 9+4k..12+4k, MSB first: bit offset = 32k + 8*(3-lane)
  assign ddc_rel = byte_no - 16'd9;
  assign ddc_off = OFFW'({ddc_rel[15:2], ~ddc_rel[1:0], 3'b000});

  // destination port selects which decoder runs after the sequence number
  always_comb begin
    case (to_port)
      16'd1024: port_stream = ST_GEN;
      16'd1027: port_stream = ST_HP;
      16'd1029: port_stream = ST_IQ;
      default:  port_stream = ST_NONE;
    endcase
  end

  // packet framing FSM and saturating byte counter
  always_ff @(posedge rx_clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stream  <= ST_NONE;
      byte_no <= '0;
      armed   <= 1'b0;
    end else begin
      if (!udp_rx_active) armed <= 1'b1;
      if (start) begin
        stream  <= port_stream;
        byte_no <= 16'd1;
        state   <= SEQ;
      end else if (pkt_end) begin
        state <= IDLE;
      end else if (byte_in) begin
        if (byte_no != 16'hFFFF) byte_no <= byte_no + 16'd1;
        case (state)
          SEQ: if (byte_no == 16'd3) begin
            case (stream)
              ST_GEN:  state <= GENERAL;
              ST_HP:   state <= HIGH_PRI;
              ST_IQ:   state <= TX_IQ;
              default: state <= SKIP;
            endcase
          end
          GENERAL: if (byte_no == 16'd4 && udp_rx_data != 8'h00) state <= SKIP;
          default: ;
        endcase
      end
    end
  end

  // shadow fields: seeded from committed values at packet start, filled per byte
  always_ff @(posedge rx_clock or negedge rst_n) begin
    if (!rst_n) begin
      sh_run <= 1'b0;
      sh_ptt <= 1'b0;
      sh_wb  <= 1'b0;
      sh_ppf <= 8'd1;
      sh_rx  <= '0;
      sh_tx  <= '0;
    end else if (start) begin
      sh_run <= run;
      sh_ptt <= ptt;
      sh_wb  <= wideband;
      sh_ppf <= wb_packets_per_frame;
      sh_rx  <= rx_freq;
      sh_tx  <= tx_freq;
    end else if (byte_in) begin
      if (state == GENERAL) begin
        if (byte_no == 16'd23) sh_wb  <= udp_rx_data[0];
        if (byte_no == 16'd28) sh_ppf <= udp_rx_data;
      end
      if (state == HIGH_PRI) begin
        if (byte_no == 16'd4) begin
          sh_run <= udp_rx_data[0];
          sh_ptt <= udp_rx_data[1];
        end
        if (byte_no >= 16'd9 && byte_no < DDC_END) sh_rx[ddc_off +: 8] <= udp_rx_data;
        case (byte_no)
          16'd329: sh_tx[31:24] <= udp_rx_data;
          16'd330: sh_tx[23:16] <= udp_rx_data;
          16'd331: sh_tx[15:8]  <= udp_rx_data;
          16'd332: sh_tx[7:0]   <= udp_rx_data;
          default: ;
        endcase
      end
    end
  end

  // committed control outputs and discovery handshake
  always_ff @(posedge rx_clock or negedge rst_n) begin
    if (!rst_n) begin
      discovery            <= 1'b0;
      run                  <= 1'b0;
      ptt                  <= 1'b0;
      wideband             <= 1'b0;
      wb_packets_per_frame <= 8'd1;
      rx_freq              <= '0;
      tx_freq              <= '0;
      hp_update            <= 1'b0;
    end else begin
      hp_update <= hp_commit;
      if (gen_commit) begin
        wideband             <= sh_wb;
        wb_packets_per_frame <= sh_ppf;
      end
      if (hp_commit) begin
        run     <= sh_run;
        ptt     <= sh_run & sh_ptt;
        rx_freq <= sh_rx;
        tx_freq <= sh_tx;
      end
      if (disc_set)           discovery <= 1'b1;
      else if (discovery_ACK) discovery <= 1'b0;
    end
  end

  // TX I/Q byte path to the FIFO with sticky overflow
  always_ff @(posedge rx_clock or negedge rst_n) begin
    if (!rst_n) begin
      txiq_wrreq    <= 1'b0;
      txiq_wrdata   <= '0;
      txiq_overflow <= 1'b0;
    end else begin
      txiq_wrreq <= 1'b0;
      if (run_rise) txiq_overflow <= 1'b0;
      if (byte_in && state == TX_IQ) begin
        txiq_wrreq  <= !txiq_full;
        txiq_wrdata <= udp_rx_data;
        if (txiq_full) txiq_overflow <= 1'b1;
      end
    end
  end

`ifdef SDR_RX_SEQ_CHECK_EN
  logic [23:0] seq_sh;
  logic [31:0] seq_full, exp_hp, exp_iq;
  logic        vld_hp, vld_iq, seq_done;

  assign seq_full = {seq_sh, udp_rx_data};
  assign seq_done = byte_in && (state == SEQ) && (byte_no == 16'd3);

  // per-stream expected sequence tracking; cleared when the radio stops
  always_ff @(posedge rx_clock or negedge rst_n) begin
    if (!rst_n) begin
      seq_sh     <= '0;
      exp_hp     <= '0;
      exp_iq     <= '0;
      vld_hp     <= 1'b0;
      vld_iq     <= 1'b0;
      seq_err_hp <= '0;
      seq_err_iq <= '0;
    end else begin
      if (start)                       seq_sh <= {16'h0, udp_rx_data};
      else if (byte_in && state == SEQ) seq_sh <= {seq_sh[15:0], udp_rx_data};
      if (run_fall) begin
        vld_hp     <= 1'b0;
        vld_iq     <= 1'b0;
        seq_err_hp <= '0;
        seq_err_iq <= '0;
      end else if (seq_done) begin
        if (stream == ST_HP) begin
          if (vld_hp && seq_full != exp_hp && seq_err_hp != 16'hFFFF)
            seq_err_hp <= seq_err_hp + 16'd1;
          exp_hp <= seq_full + 32'd1;
          vld_hp <= 1'b1;
        end
        if (stream == ST_IQ) begin
          if (vld_iq && seq_full != exp_iq && seq_err_iq != 16'hFFFF)
            seq_err_iq <= seq_err_iq + 16'd1;
          exp_iq <= seq_full + 32'd1;
          vld_iq <= 1'b1;
        end
      end
    end
  end
`else
  assign seq_err_hp = '0;
  assign seq_err_iq = '0;
`endif

endmodule

// File: tb/tb_sdr_receive.sv
// tb_sdr_receive: directed-vector bench for sdr_receive.
module tb_sdr_receive;
  localparam int NR = 2;
`ifdef SDR_RX_SEQ_CHECK_EN
  localparam logic [15:0] EXP_SEQ_ERR = 16'd1;
`else
  localparam logic [15:0] EXP_SEQ_ERR = 16'd0;
`endif

  logic             rx_clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             udp_rx_active = 1'b0;
  logic [7:0]       udp_rx_data = 8'h00;
  logic [15:0]      to_port = 16'h0;
  logic             discovery_ACK = 1'b0;
  logic             txiq_full = 1'b0;
  logic             discovery, run, ptt, wideband, hp_update, txiq_wrreq, txiq_overflow;
  logic [7:0]       wb_packets_per_frame, txiq_wrdata;
  logic [32*NR-1:0] rx_freq;
  logic [31:0]      tx_freq;
  logic [15:0]      seq_err_hp, seq_err_iq;

  sdr_receive #(.NR(NR), .HP_MIN_LEN(16'd333)) dut (
    .rx_clock(rx_clock), .rst_n(rst_n), .udp_rx_active(udp_rx_active),
    .udp_rx_data(udp_rx_data), .to_port(to_port), .discovery_ACK(discovery_ACK),
    .txiq_full(txiq_full), .discovery(discovery), .run(run), .ptt(ptt),
    .wideband(wideband), .wb_packets_per_frame(wb_packets_per_frame),
    .rx_freq(rx_freq), .tx_freq(tx_freq), .hp_update(hp_update),
    .txiq_wrreq(txiq_wrreq), .txiq_wrdata(txiq_wrdata), .txiq_overflow(txiq_overflow),
    .seq_err_hp(seq_err_hp), .seq_err_iq(seq_err_iq)
  );

  always #5 rx_clock = ~rx_clock;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle counter and output monitors
  int cyc = 0;
  always @(posedge rx_clock) cyc <= cyc + 1;

  int wr_cnt = 0, hp_cnt = 0, disc_cyc = -1, b4_cyc = 0;
  logic [7:0] wq[$];
  always @(negedge rx_clock) begin
    if (txiq_wrreq) begin
      wr_cnt++;
      wq.push_back(txiq_wrdata);
    end
    if (hp_update) hp_cnt++;
    if (discovery && disc_cyc < 0) disc_cyc = cyc;
  end

  logic [7:0] pb [0:1499];

  task automatic clr_pb;
    for (int i = 0; i < 1500; i++) pb[i] = 8'h00;
  endtask

  task automatic hp_pb(input logic [31:0] s, input logic [7:0] cmd,
                       input logic [31:0] f0, input logic [31:0] tx);
    clr_pb();
    {pb[0], pb[1], pb[2], pb[3]}         = s;
    pb[4]                                = cmd;
    {pb[9], pb[10], pb[11], pb[12]}      = f0;
    {pb[329], pb[330], pb[331], pb[332]} = tx;
  endtask

  task automatic iq_pb;
    clr_pb();
    for (int i = 4; i < 1500; i++) pb[i] = 8'(i) ^ 8'h5A;
  endtask

  task automatic send(input logic [15:0] port, input int len, input int flo, input int fhi);
    for (int i = 0; i < len; i++) begin
      @(negedge rx_clock);
      to_port       = port;
      udp_rx_active = 1'b1;
      udp_rx_data   = pb[i];
      txiq_full     = (i >= flo && i <= fhi);
      if (i == 4) b4_cyc = cyc;
    end
    @(negedge rx_clock);
    udp_rx_active = 1'b0;
    udp_rx_data   = 8'h00;
    txiq_full     = 1'b0;
  endtask

  // one cycle after the end of a packet, past the monitors
  task automatic after_pkt;
    @(negedge rx_clock);
    #1;
  endtask

  initial begin
    int h0, w0, snap, bad, k;
    // reset state
    repeat (2) @(negedge rx_clock);
    #1;
    chk("rst_disc", discovery, 0);
    chk("rst_run", run, 0);
    chk("rst_ppf", wb_packets_per_frame, 8'd1);
    chk("rst_rxf", rx_freq, 0);
    chk("rst_ovf", txiq_overflow, 0);
    @(negedge rx_clock);
    rst_n = 1'b1;
    repeat (2) @(negedge rx_clock);

    // discovery request and acknowledge
    clr_pb();
    pb[4] = 8'h02;
    disc_cyc = -1;
    send(16'd1024, 60, -1, -1);
    after_pkt();
    chk("disc_lat", 64'(disc_cyc - b4_cyc), 1);
    chk("disc_set", discovery, 1);
    chk("disc_no_wb", wideband, 0);
    @(negedge rx_clock); discovery_ACK = 1'b1;
    @(negedge rx_clock); discovery_ACK = 1'b0; #1;
    chk("disc_ack", discovery, 0);

    // full High Priority packet
    hp_pb(32'd0, 8'h03, 32'h01020304, 32'hAABBCCDD);
    h0 = hp_cnt;
    send(16'd1027, 1444, -1, -1);
    after_pkt();
    chk("hp_pulse", hp_update, 1);
    chk("hp_run", run, 1);
    chk("hp_ptt", ptt, 1);
    chk("hp_rx0", rx_freq[31:0], 32'h01020304);
    chk("hp_rx1", rx_freq[63:32], 32'h0);
    chk("hp_tx", tx_freq, 32'hAABBCCDD);
    after_pkt();
    chk("hp_cnt", hp_cnt - h0, 1);

    // truncated packet and one byte short of the minimum: discarded
    hp_pb(32'd1, 8'h00, 32'h11223344, 32'h55667788);
    h0 = hp_cnt;
    send(16'd1027, 200, -1, -1);
    after_pkt();
    hp_pb(32'd1, 8'h01, 32'h11223344, 32'h55667788);
    send(16'd1027, 332, -1, -1);
    after_pkt(); after_pkt();
    chk("tr_run", run, 1);
    chk("tr_ptt", ptt, 1);
    chk("tr_rx0", rx_freq[31:0], 32'h01020304);
    chk("tr_tx", tx_freq, 32'hAABBCCDD);
    chk("tr_hp", hp_cnt - h0, 0);

    // exactly the minimum length commits
    send(16'd1027, 333, -1, -1);
    after_pkt(); after_pkt();
    chk("min_ptt", ptt, 0);
    chk("min_rx0", rx_freq[31:0], 32'h11223344);
    chk("min_tx", tx_freq, 32'h55667788);
    chk("min_hp", hp_cnt - h0, 1);

    // General wideband settings, with length boundary at byte 28
    clr_pb(); pb[23] = 8'h01; pb[28] = 8'h08;
    send(16'd1024, 60, -1, -1);
    after_pkt();
    chk("wb_on", wideband, 1);
    chk("wb_ppf", wb_packets_per_frame, 8'd8);
    clr_pb(); pb[28] = 8'h03;
    send(16'd1024, 28, -1, -1);
    after_pkt();
    chk("wb_short", wideband, 1);
    send(16'd1024, 29, -1, -1);
    after_pkt();
    chk("wb_off", wideband, 0);
    chk("wb_ppf29", wb_packets_per_frame, 8'd3);

    // TX I/Q with FIFO full for bytes 100-109
    iq_pb();
    wq.delete();
    w0 = wr_cnt;
    send(16'd1029, 1444, 100, 109);
    after_pkt();
    chk("iq_cnt", wr_cnt - w0, 1430);
    chk("iq_ovf", txiq_overflow, 1);
    bad = 0; k = 0;
    for (int i = 4; i < 1444; i++) begin
      if (i < 100 || i > 109) begin
        if (k >= wq.size() || wq[k] !== pb[i]) bad++;
        k++;
      end
    end
    chk("iq_order", bad, 0);

    // run 0 keeps overflow sticky
    hp_pb(32'd9, 8'h00, 32'h0, 32'h0);
    send(16'd1027, 333, -1, -1);
    after_pkt();
    chk("stop_run", run, 0);
    chk("stop_ovf", txiq_overflow, 1);

    // sequence numbers 0,1,3,4 with run on, then run off
    hp_pb(32'd0, 8'h01, 32'h0A0B0C0D, 32'h01010101);
    send(16'd1027, 333, -1, -1);
    after_pkt();
    chk("rise_ovf", txiq_overflow, 0);
    chk("rise_ptt", ptt, 0);
    hp_pb(32'd1, 8'h01, 32'h0A0B0C0D, 32'h01010101); send(16'd1027, 333, -1, -1);
    hp_pb(32'd3, 8'h01, 32'h0A0B0C0D, 32'h01010101); send(16'd1027, 333, -1, -1);
    hp_pb(32'd4, 8'h01, 32'h0A0B0C0D, 32'h01010101); send(16'd1027, 333, -1, -1);
    after_pkt();
    chk("seq_err", seq_err_hp, EXP_SEQ_ERR);
    hp_pb(32'd5, 8'h00, 32'h0A0B0C0D, 32'h01010101); send(16'd1027, 333, -1, -1);
    after_pkt();
    chk("seq_clr", seq_err_hp, 0);
    chk("seq_iq", seq_err_iq, 0);

    // reset at byte 500 of a TX I/Q packet
    iq_pb();
    snap = 0;
    for (int i = 0; i < 1444; i++) begin
      @(negedge rx_clock);
      to_port = 16'd1029; udp_rx_active = 1'b1; udp_rx_data = pb[i];
      txiq_full = (i >= 10 && i <= 12);
      if (i == 500) begin
        rst_n = 1'b0;
        #1;
        chk("mr_wrreq", txiq_wrreq, 0);
        chk("mr_wrdata", txiq_wrdata, 0);
        chk("mr_ovf", txiq_overflow, 0);
        chk("mr_ppf", wb_packets_per_frame, 8'd1);
        chk("mr_rxf", rx_freq, 0);
        chk("mr_txf", tx_freq, 0);
        chk("mr_misc", {discovery, run, ptt, wideband, hp_update}, 0);
      end
      if (i == 505) snap = wr_cnt;
      if (i == 510) rst_n = 1'b1;
    end
    @(negedge rx_clock);
    udp_rx_active = 1'b0; txiq_full = 1'b0;
    after_pkt();
    chk("mr_nowr", wr_cnt - snap, 0);
    w0 = wr_cnt;
    send(16'd1029, 10, -1, -1);
    after_pkt();
    chk("mr_next", wr_cnt - w0, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
